// File: rtl/mux_4x32_pkg.sv
// Shared constants and select encoding for the registered 4:1 word multiplexer.
package mux_4x32_pkg;

  localparam int WIDTH_DEFAULT = 32;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_A0 = 2'b00;
  localparam sel_t SEL_A1 = 2'b01;
  localparam sel_t SEL_A2 = 2'b10;
  localparam sel_t SEL_A3 = 2'b11;

endpackage

// File: rtl/mux_4x32_comb.sv
// Purely combinational 4:1 word selector; an unknown select yields all-X
// in simulation while synthesis treats the decode as complete.
module mux_4x32_comb
  import mux_4x32_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [1:0]       s,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] a2,
  input  logic [WIDTH-1:0] a3,
  output logic [WIDTH-1:0] sel_w
);

  // Decode the select into the chosen operand.
  always_comb begin
    sel_w = {WIDTH{1'b0}};
    case (sel_t'(s))
      SEL_A0:  sel_w = a0;
      SEL_A1:  sel_w = a1;
      SEL_A2:  sel_w = a2;
      SEL_A3:  sel_w = a3;
      default: sel_w = {WIDTH{1'bx}};
    endcase
  end

endmodule

// File: rtl/mux_4x32.sv
// Registered 4:1 word multiplexer with capture enable and synchronous reset.
// Define MUX_4X32_SEL_ECHO_EN to add the s_q output carrying the captured select.
module mux_4x32
  import mux_4x32_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       s,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] a2,
  input  logic [WIDTH-1:0] a3,
`ifdef MUX_4X32_SEL_ECHO_EN
  output logic [1:0]       s_q,
`endif
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] w_sel;
  logic [WIDTH-1:0] r_y;

  mux_4x32_comb #(
    .WIDTH (WIDTH)
  ) u_comb (
    .s     (s),
    .a0    (a0),
    .a1    (a1),
    .a2    (a2),
    .a3    (a3),
    .sel_w (w_sel)
  );

  // Output register: reset dominates, enable low holds the previous word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_y <= {WIDTH{1'b0}};
    end else if (en) begin
      r_y <= w_sel;
    end
  end

  assign y = r_y;

`ifdef MUX_4X32_SEL_ECHO_EN
  logic [1:0] r_s_q;

  // Select echo register, captured alongside y so the two stay aligned.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s_q <= SEL_A0;
    end else if (en) begin
      r_s_q <= s;
    end
  end

  assign s_q = r_s_q;
`endif

endmodule

// File: tb/tb_mux_4x32.sv
// Self-checking bench for mux_4x32: directed scenarios plus randomized traffic
// against a behavioural model of the registered selector.
module tb_mux_4x32;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [1:0]  s;
  logic [31:0] a0, a1, a2, a3;
  logic [31:0] y;
  logic [1:0]  s_q_obs;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_y;
  logic [1:0]  exp_sq;

  mux_4x32 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .s     (s),
    .a0    (a0),
    .a1    (a1),
    .a2    (a2),
    .a3    (a3),
`ifdef MUX_4X32_SEL_ECHO_EN
    .s_q   (s_q_obs),
`endif
    .y     (y)
  );

`ifndef MUX_4X32_SEL_ECHO_EN
  assign s_q_obs = 2'b00;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock: model what the rising edge does with the present inputs,
  // then land 1 time unit after the edge, where outputs are sampled.
  task automatic tick();
    logic [31:0] ops [4];
    ops[0] = a0; ops[1] = a1; ops[2] = a2; ops[3] = a3;
    if (rst_n === 1'b0) begin
      exp_y  = 32'h0;
      exp_sq = 2'b00;
    end else if (en === 1'b1) begin
      exp_y  = ops[s];
      exp_sq = s;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_std_ops();
    a0 = 32'h0000_0000; a1 = 32'h0000_FFFF; a2 = 32'hFFFF_0000; a3 = 32'hFFFF_FFFF;
  endtask

  task automatic test_reset();
    set_std_ops();
    rst_n = 1'b0; en = 1'b1; s = 2'b11;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (y !== 32'h0000_0000) begin
        n_fail++;
        $display("FAIL reset_y cycle %0d: got %h expected 00000000", i, y);
      end
`ifdef MUX_4X32_SEL_ECHO_EN
      n_checks++;
      if (s_q_obs !== 2'b00) begin
        n_fail++;
        $display("FAIL reset_sq cycle %0d: got %b expected 00", i, s_q_obs);
      end
`endif
    end
    rst_n = 1'b1;
  endtask

  task automatic test_sweep();
    logic [31:0] want [4];
    want[0] = 32'h0000_0000; want[1] = 32'h0000_FFFF;
    want[2] = 32'hFFFF_0000; want[3] = 32'hFFFF_FFFF;
    set_std_ops();
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s = 2'(i);
      tick();
      n_checks++;
      if (y !== want[i]) begin
        n_fail++;
        $display("FAIL sweep_y s=%0d: got %h expected %h", i, y, want[i]);
      end
`ifdef MUX_4X32_SEL_ECHO_EN
      n_checks++;
      if (s_q_obs !== 2'(i)) begin
        n_fail++;
        $display("FAIL sweep_sq s=%0d: got %b expected %b", i, s_q_obs, 2'(i));
      end
`endif
    end
  endtask

  task automatic test_hold();
    set_std_ops();
    en = 1'b1; s = 2'b10;
    tick();
    n_checks++;
    if (y !== 32'hFFFF_0000) begin
      n_fail++;
      $display("FAIL hold_capture: got %h expected ffff0000", y);
    end
    en = 1'b0; s = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (y !== 32'hFFFF_0000) begin
        n_fail++;
        $display("FAIL hold_y cycle %0d: got %h expected ffff0000", i, y);
      end
`ifdef MUX_4X32_SEL_ECHO_EN
      n_checks++;
      if (s_q_obs !== 2'b10) begin
        n_fail++;
        $display("FAIL hold_sq cycle %0d: got %b expected 10", i, s_q_obs);
      end
`endif
    end
    en = 1'b1;
    tick();
    n_checks++;
    if (y !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL hold_release: got %h expected ffffffff", y);
    end
  endtask

  task automatic test_data_change();
    set_std_ops();
    en = 1'b1; s = 2'b01;
    tick();
    n_checks++;
    if (y !== 32'h0000_FFFF) begin
      n_fail++;
      $display("FAIL data_before: got %h expected 0000ffff", y);
    end
    #2;
    a1 = 32'h1234_5678;
    #1;
    n_checks++;
    if (y !== 32'h0000_FFFF) begin
      n_fail++;
      $display("FAIL data_midcycle: got %h expected 0000ffff", y);
    end
    tick();
    n_checks++;
    if (y !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL data_after: got %h expected 12345678", y);
    end
  endtask

  task automatic test_mid_reset();
    set_std_ops();
    en = 1'b1; s = 2'b11;
    tick();
    rst_n = 1'b0; s = 2'b01;
    tick();
    n_checks++;
    if (y !== 32'h0000_0000) begin
      n_fail++;
      $display("FAIL midreset_y: got %h expected 00000000", y);
    end
    rst_n = 1'b1; s = 2'b10;
    tick();
    n_checks++;
    if (y !== 32'hFFFF_0000) begin
      n_fail++;
      $display("FAIL midreset_release: got %h expected ffff0000", y);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) begin
      a0 = $urandom; a1 = $urandom; a2 = $urandom; a3 = $urandom;
      s     = 2'($urandom_range(0, 3));
      en    = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 19) != 0);
      tick();
      n_checks++;
      if (y !== exp_y) begin
        n_fail++;
        $display("FAIL random_y iter %0d: got %h expected %h", i, y, exp_y);
      end
`ifdef MUX_4X32_SEL_ECHO_EN
      n_checks++;
      if (s_q_obs !== exp_sq) begin
        n_fail++;
        $display("FAIL random_sq iter %0d: got %b expected %b", i, s_q_obs, exp_sq);
      end
`endif
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; s = 2'b00;
    exp_y = 32'h0; exp_sq = 2'b00;
    set_std_ops();
    #1;
    test_reset();
    test_sweep();
    test_hold();
    test_data_change();
    test_mid_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
